// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI read/write channel arbiters: FSM state codes,
// master count and one-hot grant constants.
package axi_arb_pkg;

  localparam int unsigned NUM_MASTERS = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [NUM_MASTERS-1:0] GRNT_NONE = 4'b0000;
  localparam logic [NUM_MASTERS-1:0] GRNT_M0   = 4'b0001;
  localparam logic [NUM_MASTERS-1:0] GRNT_M1   = 4'b0010;
  localparam logic [NUM_MASTERS-1:0] GRNT_M2   = 4'b0100;
  localparam logic [NUM_MASTERS-1:0] GRNT_M3   = 4'b1000;

  function automatic logic [NUM_MASTERS-1:0] grnt_onehot(input logic [1:0] id);
    logic [NUM_MASTERS-1:0] g;
    case (id)
      2'd0:    g = GRNT_M0;
      2'd1:    g = GRNT_M1;
      2'd2:    g = GRNT_M2;
      default: g = GRNT_M3;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: searches rr_ptr+1, +2, +3, rr_ptr
// and returns the first requesting index.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] rr_ptr,
  output logic       valid,
  output logic [1:0] winner
);

  logic [1:0] cand;

  always_comb begin
    valid  = 1'b0;
    winner = rr_ptr;
    cand   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = rr_ptr + 2'(i);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/axi_arbiter_w_rr.sv
// Round-robin AXI write-channel arbiter for four masters; grant held AW -> WLAST -> B.
// Optional watchdog enabled by defining AXI_ARB_W_TIMEOUT_EN.
module axi_arbiter_w_rr
  import axi_arb_pkg::*;
#(
  parameter int          TCO            = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       m0_AWVALID,
  input  logic       m1_AWVALID,
  input  logic       m2_AWVALID,
  input  logic       m3_AWVALID,
  input  logic       s_AWVALID,
  input  logic       s_AWREADY,
  input  logic       s_WVALID,
  input  logic       s_WREADY,
  input  logic       s_WLAST,
  input  logic       s_BVALID,
  input  logic       s_BREADY,
  output logic       m0_wgrnt,
  output logic       m1_wgrnt,
  output logic       m2_wgrnt,
  output logic       m3_wgrnt,
  output logic [1:0] wgrnt_id,
  output logic       busy
`ifdef AXI_ARB_W_TIMEOUT_EN
  ,
  output logic       timeout_err
`endif
);

  // TCO is a simulation-only delay kept for parameter compatibility; it has no hardware effect.
  if (TCO < 0 || TIMEOUT_CYCLES == 0) begin : g_cfg_out_of_range
  end

  logic [1:0]             state;
  logic [1:0]             rr_ptr;
  logic [NUM_MASTERS-1:0] grnt;
  logic                   aw_done;
  logic                   w_done;
  logic                   pick_valid;
  logic [1:0]             pick_id;
  logic                   aw_hs;
  logic                   w_hs;
  logic                   b_hs;

  assign aw_hs = s_AWVALID & s_AWREADY;
  assign w_hs  = s_WVALID & s_WREADY & s_WLAST;
  assign b_hs  = s_BVALID & s_BREADY;

  assign {m3_wgrnt, m2_wgrnt, m1_wgrnt, m0_wgrnt} = grnt;

  rr_pick4 u_pick (
    .req    ({m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID}),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_id)
  );

`ifdef AXI_ARB_W_TIMEOUT_EN
  localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wd_cnt;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= IDLE;
      rr_ptr   <= 2'd3;
      grnt     <= GRNT_NONE;
      wgrnt_id <= '0;
      busy     <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
`ifdef AXI_ARB_W_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef AXI_ARB_W_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grnt     <= grnt_onehot(pick_id);
            wgrnt_id <= pick_id;
            busy     <= 1'b1;
            rr_ptr   <= pick_id;
            state    <= XFER;
          end
        end
        XFER: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          // Completion is judged on registered-or-current flags so same-cycle AW/WLAST moves on at once.
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= RESP;
        end
        RESP: begin
          if (b_hs) begin
            grnt    <= GRNT_NONE;
            busy    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef AXI_ARB_W_TIMEOUT_EN
      // Watchdog placed after the FSM so a forced release overrides the normal next state.
      if (state == XFER || state == RESP) begin
        if (aw_hs || w_hs || b_hs) begin
          wd_cnt <= '0;
        end else if (wd_cnt == WD_LAST) begin
          wd_cnt      <= '0;
          grnt        <= GRNT_NONE;
          busy        <= 1'b0;
          aw_done     <= 1'b0;
          w_done      <= 1'b0;
          state       <= IDLE;
          timeout_err <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
`endif
    end
  end

endmodule
